// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants shared by the timing generator and the sync receiver,
// plus the receiver's lock-state encoding.
package vga_timing_pkg;
    localparam int H_TOTAL     = 800;
    localparam int H_PULSE     = 96;
    localparam int H_BP        = 48;
    localparam int H_ACTIVE    = 640;
    localparam int V_TOTAL     = 521;
    localparam int V_PULSE     = 2;
    localparam int V_BP        = 29;
    localparam int V_ACTIVE    = 480;
    localparam int H_TOL       = 2;
    localparam int LOCK_FRAMES = 2;

    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous active-low sync pin, with rise/fall pulses
// decoded from the synchronized value. Flops reset to the idle (high) level.
module sync_edge_detect (
    input  logic clk_25,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);
    logic meta, sync, prev;

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= sig_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel position and data-enable from incoming h_sync/v_sync, measures line and
// frame timing against nominal and reports lock.
//   state   | meaning
//   SEARCH  | no frame reference yet, waiting for a v_sync fall
//   ACQUIRE | counting consecutive good frames toward lock
//   LOCKED  | timing verified, de/x/y valid
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int CFG_H_TOTAL     = H_TOTAL,
    parameter int CFG_H_PULSE     = H_PULSE,
    parameter int CFG_H_BP        = H_BP,
    parameter int CFG_H_ACTIVE    = H_ACTIVE,
    parameter int CFG_V_TOTAL     = V_TOTAL,
    parameter int CFG_V_PULSE     = V_PULSE,
    parameter int CFG_V_BP        = V_BP,
    parameter int CFG_V_ACTIVE    = V_ACTIVE,
    parameter int CFG_H_TOL       = H_TOL,
    parameter int CFG_LOCK_FRAMES = LOCK_FRAMES
) (
    input  logic             clk_25,
    input  logic             reset_n,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    output logic             locked,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic [CNT_W-1:0] h_meas,
    output logic [CNT_W-1:0] v_meas,
    output logic [7:0]       err_cnt
);
    localparam logic [CNT_W:0]   H_LEN_MIN = (CNT_W+1)'(CFG_H_TOTAL - CFG_H_TOL);
    localparam logic [CNT_W:0]   H_LEN_MAX = (CNT_W+1)'(CFG_H_TOTAL + CFG_H_TOL);
    localparam logic [CNT_W:0]   HP_MIN    = (CNT_W+1)'(CFG_H_PULSE - CFG_H_TOL);
    localparam logic [CNT_W:0]   HP_MAX    = (CNT_W+1)'(CFG_H_PULSE + CFG_H_TOL);
    localparam logic [CNT_W:0]   V_LEN_NOM = (CNT_W+1)'(CFG_V_TOTAL);
    localparam logic [CNT_W:0]   VP_NOM    = (CNT_W+1)'(CFG_V_PULSE);
    localparam logic [CNT_W:0]   ONE_L     = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_START  = CNT_W'(CFG_H_PULSE + CFG_H_BP);
    localparam logic [CNT_W-1:0] H_END    = CNT_W'(CFG_H_PULSE + CFG_H_BP + CFG_H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(CFG_V_PULSE + CFG_V_BP);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(CFG_V_PULSE + CFG_V_BP + CFG_V_ACTIVE);
    localparam logic [3:0]       LOCK_N   = 4'(CFG_LOCK_FRAMES);

    logic hs_rise, hs_fall, vs_rise, vs_fall;

    sync_edge_detect u_hs (.clk_25(clk_25), .reset_n(reset_n), .sig_in(h_sync_in),
                           .rise(hs_rise), .fall(hs_fall));
    sync_edge_detect u_vs (.clk_25(clk_25), .reset_n(reset_n), .sig_in(v_sync_in),
                           .rise(vs_rise), .fall(vs_fall));

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W:0]   h_len, v_len;
    logic             h_sat, h_pulse_ok, v_pulse_ok, frame_bad;
    logic             line_ok, line_bad, frame_ok;
    rx_state_t        state, state_nx;
    logic [3:0]       good, good_nx;
    logic [7:0]       err_nx;
    logic             leave_lock;

    // Lengths are one wider than the counters so a saturated count never aliases to a pass.
    assign h_len    = {1'b0, h_cnt} + ONE_L;
    assign v_len    = {1'b0, v_cnt} + ONE_L;
    assign h_sat    = (h_cnt == CNT_MAX);
    assign line_ok  = (h_len >= H_LEN_MIN) && (h_len <= H_LEN_MAX) && h_pulse_ok;
    assign line_bad = hs_fall && !line_ok;
    assign frame_ok = !frame_bad && !line_bad && (v_len == V_LEN_NOM) && v_pulse_ok;

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            h_meas     <= '0;
            v_meas     <= '0;
            h_pulse_ok <= 1'b0;
            v_pulse_ok <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_cnt      <= '0;
                h_meas     <= h_sat ? CNT_MAX : h_len[CNT_W-1:0];
                h_pulse_ok <= 1'b0;
            end else if (!h_sat) begin
                h_cnt <= h_cnt + ONE;
            end
            if (hs_rise) h_pulse_ok <= (h_len >= HP_MIN) && (h_len <= HP_MAX);

            if (vs_fall) begin
                v_cnt  <= '0;
                v_meas <= (v_cnt == CNT_MAX) ? CNT_MAX : v_len[CNT_W-1:0];
            end else if (hs_fall && v_cnt != CNT_MAX) begin
                v_cnt <= v_cnt + ONE;
            end

            if (vs_rise)      v_pulse_ok <= (v_len == VP_NOM);
            else if (vs_fall) v_pulse_ok <= 1'b0;

            if (vs_fall)       frame_bad <= 1'b0;
            else if (line_bad) frame_bad <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        good_nx    = good;
        err_nx     = err_cnt;
        leave_lock = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nx = ACQUIRE;
                    good_nx  = '0;
                end
            end
            ACQUIRE: begin
                if (vs_fall) begin
                    if (!frame_ok) begin
                        good_nx = '0;
                    end else if (good + 4'd1 >= LOCK_N) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                    end else begin
                        good_nx = good + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (vs_fall && !frame_ok)) begin
                    state_nx   = ACQUIRE;
                    good_nx    = '0;
                    leave_lock = 1'b1;
                end
            end
            default: begin
                state_nx = SEARCH;
                good_nx  = '0;
            end
        endcase
        // A line counter pinned at full scale means h_sync has gone away entirely.
        if (h_sat) begin
            state_nx   = SEARCH;
            good_nx    = '0;
            leave_lock = (state == LOCKED);
        end
        if (leave_lock && err_cnt != 8'hFF) err_nx = err_cnt + 8'd1;
    end

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            state   <= SEARCH;
            good    <= '0;
            err_cnt <= '0;
            locked  <= 1'b0;
        end else begin
            state   <= state_nx;
            good    <= good_nx;
            err_cnt <= err_nx;
            locked  <= (state_nx == LOCKED);
        end
    end

    always_ff @(posedge clk_25) begin
        if (!reset_n) begin
            de <= 1'b0;
            x  <= '0;
            y  <= '0;
        end else if (locked && h_cnt >= H_START && h_cnt < H_END
                            && v_cnt >= V_START && v_cnt < V_END) begin
            de <= 1'b1;
            x  <= h_cnt - H_START;
            y  <= v_cnt - V_START;
        end else begin
            de <= 1'b0;
            x  <= '0;
            y  <= '0;
        end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a scaled-down raster so many frames fit in a short run;
// a timestamp-based reference model is compared against every output on every cycle.
module tb_vga_sync_receiver;
    localparam int HT = 40, HP = 6, HB = 4, HA = 24;
    localparam int VT = 20, VP = 2, VB = 3, VA = 12;
    localparam int TOL = 2, LK = 2;
    localparam int HS = HP + HB, VS = VP + VB;

    logic       clk_25, reset_n, h_sync_in, v_sync_in;
    logic       locked, de;
    logic [9:0] x, y, h_meas, v_meas;
    logic [7:0] err_cnt;

    vga_sync_receiver #(
        .CFG_H_TOTAL(HT), .CFG_H_PULSE(HP), .CFG_H_BP(HB), .CFG_H_ACTIVE(HA),
        .CFG_V_TOTAL(VT), .CFG_V_PULSE(VP), .CFG_V_BP(VB), .CFG_V_ACTIVE(VA),
        .CFG_H_TOL(TOL), .CFG_LOCK_FRAMES(LK)
    ) dut (
        .clk_25(clk_25), .reset_n(reset_n), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .locked(locked), .de(de), .x(x), .y(y), .h_meas(h_meas), .v_meas(v_meas),
        .err_cnt(err_cnt)
    );

    initial begin
        clk_25 = 1'b0;
        forever #20 clk_25 = ~clk_25;
    end

    int total = 0, bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: pin samples pass a 3-deep window (sync + edge register), positions are
    // derived from the edge index of the last detected h_sync fall, lock from frame verdicts.
    int cyc = 0;
    bit hp1, hp2, hp3, vp1, vp2, vp3;
    int t_hf, nl, phase, good_frames;
    bit hpg, vpg, fbad;
    int m_err, m_hmeas, m_vmeas, m_x, m_y;
    bit m_locked, m_de;

    task automatic model_step();
        int hb, vb;
        bit hf, hr, vf, vr, lbad, fok;
        cyc++;
        if (!reset_n) begin
            {hp1, hp2, hp3, vp1, vp2, vp3} = 6'b111111;
            t_hf = cyc; nl = 0; hpg = 0; vpg = 0; fbad = 0;
            phase = 0; good_frames = 0;
            m_err = 0; m_hmeas = 0; m_vmeas = 0; m_locked = 0; m_de = 0; m_x = 0; m_y = 0;
            return;
        end
        hf = hp3 && !hp2;  hr = !hp3 && hp2;
        vf = vp3 && !vp2;  vr = !vp3 && vp2;
        hp3 = hp2; hp2 = hp1; hp1 = h_sync_in;
        vp3 = vp2; vp2 = vp1; vp1 = v_sync_in;
        hb = imin(cyc - 1 - t_hf, 1023);
        vb = nl;
        m_de = m_locked && hb >= HS && hb < HS + HA && vb >= VS && vb < VS + VA;
        m_x  = m_de ? hb - HS : 0;
        m_y  = m_de ? vb - VS : 0;
        lbad = hf && !((hb + 1) >= HT - TOL && (hb + 1) <= HT + TOL && hpg);
        fok  = !fbad && !lbad && (vb + 1 == VT) && vpg;
        // phase: 0 = searching, 1 = acquiring, 2 = locked
        if (hb == 1023) begin
            if (phase == 2 && m_err < 255) m_err++;
            phase = 0; good_frames = 0;
        end else if (phase == 0) begin
            if (vf) begin phase = 1; good_frames = 0; end
        end else if (phase == 1) begin
            if (vf) begin
                if (fok) begin
                    good_frames++;
                    if (good_frames >= LK) begin phase = 2; good_frames = 0; end
                end else good_frames = 0;
            end
        end else if (lbad || (vf && !fok)) begin
            phase = 1; good_frames = 0;
            if (m_err < 255) m_err++;
        end
        if (hf) begin m_hmeas = imin(hb + 1, 1023); hpg = 0; t_hf = cyc; end
        if (hr) hpg = (hb + 1 >= HP - TOL) && (hb + 1 <= HP + TOL);
        if (vf) begin
            m_vmeas = imin(vb + 1, 1023); vpg = 0; fbad = 0; nl = 0;
        end else if (hf) begin
            if (lbad) fbad = 1;
            nl = imin(nl + 1, 1023);
        end
        if (vr) vpg = (vb + 1 == VP);
        m_locked = (phase == 2);
    endtask

    always @(posedge clk_25) begin
        #1;
        model_step();
    end

    always @(negedge clk_25) begin
        if (chk_en) begin
            chk("locked",  locked,  m_locked);
            chk("de",      de,      m_de);
            chk("x",       x,       m_x);
            chk("y",       y,       m_y);
            chk("h_meas",  h_meas,  m_hmeas);
            chk("v_meas",  v_meas,  m_vmeas);
            chk("err_cnt", err_cnt, m_err);
        end
    end

    // Independent observation of de activity and lock rise for the literal checks.
    int de_total = 0, mark_total = 0, first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    int lock_edge = -1, frame_edge = 0;
    always @(posedge clk_25) begin
        #2;
        if (de === 1'b1) begin
            if (de_total == mark_total) begin first_x = x; first_y = y; end
            last_x = x; last_y = y;
            de_total++;
        end
        if (locked === 1'b1 && lock_edge < 0) lock_edge = cyc;
    end

    task automatic send_frame(input int vpulse, input int bad_line, input int bad_len,
                              input int rst_line, input bit jitter);
        int len, hpw;
        for (int l = 0; l < VT; l++) begin
            len = (l == bad_line) ? bad_len : HT;
            hpw = HP;
            if (jitter) begin
                len = HT + $urandom_range(0, 4) - 2;
                hpw = HP + $urandom_range(0, 4) - 2;
                if ($urandom_range(0, 29) == 0) len = HT + $urandom_range(3, 6);
            end
            for (int i = 0; i < len; i++) begin
                if (l == 0 && i == 0) frame_edge = cyc + 1;
                if (l == rst_line && i == 11) begin
                    chk("rst_mid_locked", locked, 0);
                    chk("rst_mid_de", de, 0);
                    chk("rst_mid_err", err_cnt, 0);
                    chk("rst_mid_h_meas", h_meas, 0);
                    chk("rst_mid_v_meas", v_meas, 0);
                end
                h_sync_in = (i < hpw) ? 1'b0 : 1'b1;
                v_sync_in = (l < vpulse) ? 1'b0 : 1'b1;
                reset_n   = !(l == rst_line && i == 10);
                @(negedge clk_25);
            end
        end
    endtask

    task automatic good_frame();
        send_frame(VP, -1, 0, -1, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
        repeat (3) @(negedge clk_25);
        chk_en  = 1;
        reset_n = 1'b1;
        repeat ($urandom_range(3, 20)) @(negedge clk_25);
        chk("reset_locked", locked, 0);
        chk("reset_err", err_cnt, 0);
        chk("reset_de", de, 0);

        // Nominal timing: lock two edges after the third v_sync fall reaches the pins.
        good_frame(); good_frame();
        chk("pre_lock", locked, 0);
        good_frame();
        chk("lock_latency", lock_edge - frame_edge, 2);
        chk("t1_locked", locked, 1);
        chk("t1_h_meas", h_meas, HT);
        chk("t1_v_meas", v_meas, VT);

        // One full locked frame of active video.
        mark_total = de_total;
        good_frame();
        chk("de_per_frame", de_total - mark_total, HA * VA);
        chk("first_x", first_x, 0);
        chk("first_y", first_y, 0);
        chk("last_x", last_x, HA - 1);
        chk("last_y", last_y, VA - 1);

        // Stretched line drops lock, two good frames after the bad one relock.
        send_frame(VP, 8, HT + 5, -1, 1'b0);
        chk("stretch_unlocked", locked, 0);
        chk("stretch_err", err_cnt, 1);
        good_frame(); good_frame();
        chk("stretch_still_unlocked", locked, 0);
        good_frame();
        chk("stretch_relocked", locked, 1);

        // Sync loss.
        repeat (1100) @(negedge clk_25);
        chk("loss_locked", locked, 0);
        chk("loss_de", de, 0);
        chk("loss_err", err_cnt, 2);
        repeat (4) good_frame();
        chk("loss_relocked", locked, 1);

        // Single-cycle reset mid-frame while locked.
        send_frame(VP, -1, 0, 7, 1'b0);
        good_frame(); good_frame();
        chk("rst_still_unlocked", locked, 0);
        good_frame();
        chk("rst_relocked", locked, 1);

        // Randomized line lengths and pulse widths, occasional bad lines or v pulses.
        for (int f = 0; f < 8; f++)
            send_frame(($urandom_range(0, 5) == 0) ? 3 : 2, -1, 0, -1, 1'b1);

        // Three-line v_sync pulse never locks.
        reset_n = 1'b0;
        repeat (2) @(negedge clk_25);
        reset_n = 1'b1;
        repeat (4) send_frame(3, -1, 0, -1, 1'b0);
        chk("vpulse3_locked", locked, 0);
        chk("vpulse3_err", err_cnt, 0);
        chk("vpulse3_v_meas", v_meas, VT);

        repeat (10) @(negedge clk_25);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
